// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding, funct3 codes and access legality for the MEM-stage memory unit.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic legal_access(input logic [2:0] f3, input logic [1:0] off, input logic is_store);
        case (f3)
            F3_B:    return 1'b1;
            F3_H:    return !off[0];
            F3_W:    return off == 2'b00;
            F3_BU:   return !is_store;
            F3_HU:   return !is_store && !off[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/acknowledge data-memory bus between the MEM stage and data memory.
interface mem_access_unit_if #(parameter int DM_AW = 14);
    logic             dm_req;
    logic             dm_we;
    logic [3:0]       dm_be;
    logic [DM_AW-1:0] dm_addr;
    logic [31:0]      dm_wdata;
    logic [31:0]      dm_rdata;
    logic             dm_ack;

    modport master (output dm_req, dm_we, dm_be, dm_addr, dm_wdata, input dm_rdata, dm_ack);
    modport slave  (input dm_req, dm_we, dm_be, dm_addr, dm_wdata, output dm_rdata, dm_ack);
endinterface

// File: rtl/load_align.sv
// load_align: selects the addressed byte/halfword/word of a memory word and sign- or zero-extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [31:0] sh;

    always_comb begin
        sh   = word >> {off, 3'b000};
        data = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]}   :
               funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
               funct3 == F3_BU ? {24'd0, sh[7:0]}         :
               funct3 == F3_HU ? {16'd0, sh[15:0]}        :
               funct3 == F3_W  ? word                     : '0;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory controller; issues one request per access, stalls the
// pipeline until ack or timeout, and presents aligned load data for a single DONE cycle.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DM_AW    = 14,
    parameter int MAX_WAIT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_r,
    input  logic                 mem_w,
    input  logic [2:0]           funct3,
    input  logic [31:0]          addr,
    input  logic [31:0]          store_data,
    mem_access_unit_if.master    dm,
    output logic [31:0]          load_data,
    output logic                 mem_stall,
    output logic                 misalign_err,
    output logic                 timeout_err
);
    localparam logic [7:0] MAXW = 8'(MAX_WAIT);

    state_e           state_q, state_d;
    logic [DM_AW-1:0] waddr_q, waddr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             access, legal, issue, busy, cnt_hit;
    logic [3:0]       be_n;
    logic [31:0]      wdata_n, aligned;
    logic             unused_addr;

    assign unused_addr = ^addr[31:DM_AW+2];

    always_comb begin
        access  = mem_r | mem_w;
        legal   = legal_access(funct3, addr[1:0], mem_w);
        busy    = state_q == BUSY;
        // reset gates the combinational request so dm_req falls without waiting for a clock
        issue   = !rst && state_q == IDLE && access && legal;
        cnt_hit = busy && !dm.dm_ack && (cnt_q + 8'd1) == MAXW;
        be_n    = !mem_w           ? 4'b1111 :
                  funct3 == F3_W   ? 4'b1111 :
                  funct3 == F3_H   ? 4'b0011 << addr[1:0] : 4'b0001 << addr[1:0];
        wdata_n = !mem_w           ? '0 :
                  funct3 == F3_W   ? store_data :
                  funct3 == F3_H   ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            waddr_q <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        if (issue) begin
            waddr_d = addr[DM_AW+1:2];
            be_d    = be_n;
            wdata_d = wdata_n;
            we_d    = mem_w;
            f3_d    = funct3;
            off_d   = addr[1:0];
            cnt_d   = '0;
            rdata_d = dm.dm_ack ? dm.dm_rdata : '0;
            state_d = dm.dm_ack ? DONE : BUSY;
        end else if (busy) begin
            cnt_d   = cnt_q + 8'd1;
            rdata_d = dm.dm_ack ? dm.dm_rdata : cnt_hit ? '0 : rdata_q;
            state_d = (dm.dm_ack || cnt_hit) ? DONE : BUSY;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    load_align u_align (
        .word   (rdata_q),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (aligned)
    );

    always_comb begin
        dm.dm_req    = issue || busy;
        dm.dm_we     = issue ? mem_w           : busy && we_q;
        dm.dm_be     = issue ? be_n            : busy ? be_q    : '0;
        dm.dm_addr   = issue ? addr[DM_AW+1:2] : busy ? waddr_q : '0;
        dm.dm_wdata  = issue ? wdata_n         : busy ? wdata_q : '0;
        mem_stall    = issue || busy;
        misalign_err = !rst && state_q == IDLE && access && !legal;
        timeout_err  = cnt_hit;
        load_data    = (state_q == DONE && !we_q) ? aligned : '0;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed stimulus against a transaction-level model of the memory unit,
// plus literal expectations for the reference scenarios.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int AW   = 14;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_r = 1'b0, mem_w = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, store_data = '0;
    logic [31:0] load_data;
    logic        mem_stall, misalign_err, timeout_err;
    int          errors = 0, checks = 0;

    mem_access_unit_if #(.DM_AW(AW)) dm ();

    mem_access_unit #(.DM_AW(AW), .MAX_WAIT(MAXW)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_r        (mem_r),
        .mem_w        (mem_w),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .dm           (dm),
        .load_data    (load_data),
        .mem_stall    (mem_stall),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    endfunction

    function automatic bit ref_legal(input logic [2:0] f3, input logic [1:0] off, input bit st);
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        if (st && f3[2]) return 1'b0;
        return (int'(off) % nbytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] ref_be(input bit st, input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] b = '0;
        if (!st) return 4'hF;
        for (int i = 0; i < 4; i++)
            if (i >= int'(off) && i < int'(off) + nbytes(f3)) b[i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % nbytes(f3)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] word);
        logic [31:0] v = '0;
        int n = nbytes(f3);
        for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(int'(off) + i) +: 8];
        if (!f3[2] && n < 4 && v[8*n-1])
            for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    // model: an outstanding transaction, a one-cycle result slot, and a wait count
    bit          m_pend = 0, m_done = 0, n_pend = 0, n_done = 0;
    int          m_waits = 0, n_waits = 0;
    logic [31:0] m_word = '0, n_word = '0, m_sd = '0, n_sd = '0;
    logic        m_we = 0, n_we = 0;
    logic [2:0]  m_f3 = '0, n_f3 = '0;
    logic [1:0]  m_off = '0, n_off = '0;
    logic [AW-1:0] m_wa = '0, n_wa = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 0; m_done = 0; m_waits = 0; m_word = '0;
        end else begin
            m_pend = n_pend; m_done = n_done; m_waits = n_waits; m_word = n_word;
            m_sd = n_sd; m_we = n_we; m_f3 = n_f3; m_off = n_off; m_wa = n_wa;
        end
    end

    always @(negedge clk) begin
        logic e_req, e_mis, e_to, t_we;
        logic [31:0] e_load, t_sd;
        logic [2:0] t_f3;
        logic [1:0] t_off;
        logic [AW-1:0] t_wa;
        e_req = 0; e_mis = 0; e_to = 0; e_load = '0;
        t_we = m_we; t_sd = m_sd; t_f3 = m_f3; t_off = m_off; t_wa = m_wa;
        n_pend = m_pend; n_done = m_done; n_waits = m_waits; n_word = m_word;
        n_sd = m_sd; n_we = m_we; n_f3 = m_f3; n_off = m_off; n_wa = m_wa;
        if (rst) begin
            n_pend = 0; n_done = 0; n_waits = 0; n_word = '0;
        end else if (m_done) begin
            e_load = m_we ? 32'd0 : ref_load(m_f3, m_off, m_word);
            n_done = 0;
        end else if (m_pend) begin
            e_req = 1;
            n_waits = m_waits + 1;
            if (dm.dm_ack) begin
                n_word = dm.dm_rdata; n_pend = 0; n_done = 1;
            end else if (n_waits == MAXW) begin
                e_to = 1; n_word = '0; n_pend = 0; n_done = 1;
            end
        end else if (mem_r | mem_w) begin
            if (ref_legal(funct3, addr[1:0], mem_w)) begin
                e_req = 1;
                t_we = mem_w; t_sd = store_data; t_f3 = funct3; t_off = addr[1:0]; t_wa = addr[AW+1:2];
                n_we = t_we; n_sd = t_sd; n_f3 = t_f3; n_off = t_off; n_wa = t_wa; n_waits = 0;
                if (dm.dm_ack) begin
                    n_word = dm.dm_rdata; n_done = 1;
                end else n_pend = 1;
            end else e_mis = 1;
        end
        chk("dm_req", 32'(dm.dm_req), 32'(e_req));
        chk("mem_stall", 32'(mem_stall), 32'(e_req));
        chk("misalign_err", 32'(misalign_err), 32'(e_mis));
        chk("timeout_err", 32'(timeout_err), 32'(e_to));
        chk("load_data", load_data, e_load);
        if (e_req) begin
            chk("dm_we", 32'(dm.dm_we), 32'(t_we));
            chk("dm_be", 32'(dm.dm_be), 32'(ref_be(t_we, t_f3, t_off)));
            chk("dm_addr", 32'(dm.dm_addr), 32'(t_wa));
            if (t_we) chk("dm_wdata", dm.dm_wdata, ref_wdata(t_f3, t_sd));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
        mem_r = r; mem_w = w; funct3 = f3; addr = a; store_data = sd;
    endtask

    // delay < 0: access is illegal and occupies one cycle; otherwise ack arrives after delay cycles
    task automatic xact(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int delay, input logic [31:0] rd);
        drive(r, w, f3, a, sd);
        if (delay < 0) step();
        else begin
            for (int k = 0; k <= delay; k++) begin
                dm.dm_ack = (k == delay);
                dm.dm_rdata = (k == delay) ? rd : 32'hDEAD_BEEF;
                step();
            end
            dm.dm_ack = 1'b0;
            step();
        end
        drive(0, 0, 3'd0, 32'd0, 32'd0);
        step();
    endtask

    initial begin
        dm.dm_ack = 1'b0;
        dm.dm_rdata = '0;
        drive(1, 0, F3_W, 32'h10, 32'd0);
        #2;
        chk("rst_req", 32'(dm.dm_req), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_load", load_data, 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        drive(0, 0, 3'd0, 32'd0, 32'd0);
        step(); step();
        rst = 1'b0;
        step();

        drive(1, 0, F3_B, 32'h0000_1003, 32'd0);
        #1;
        chk("lb_addr", 32'(dm.dm_addr), 32'h400);
        chk("lb_be", 32'(dm.dm_be), 32'hF);
        chk("lb_stall0", 32'(mem_stall), 32'd1);
        step(); #1;
        chk("lb_stall1", 32'(mem_stall), 32'd1);
        step();
        dm.dm_ack = 1'b1; dm.dm_rdata = 32'h80AA_BBCC;
        #1;
        chk("lb_stall2", 32'(mem_stall), 32'd1);
        step();
        dm.dm_ack = 1'b0; dm.dm_rdata = 32'hDEAD_BEEF;
        #1;
        chk("lb_load", load_data, 32'hFFFF_FF80);
        chk("lb_done_stall", 32'(mem_stall), 32'd0);
        step();
        drive(0, 0, 3'd0, 32'd0, 32'd0);
        step();

        drive(0, 1, F3_H, 32'h0000_2002, 32'h1234_ABCD);
        dm.dm_ack = 1'b1;
        #1;
        chk("sh_we", 32'(dm.dm_we), 32'd1);
        chk("sh_be", 32'(dm.dm_be), 32'hC);
        chk("sh_wdata", dm.dm_wdata, 32'hABCD_ABCD);
        chk("sh_stall", 32'(mem_stall), 32'd1);
        step();
        dm.dm_ack = 1'b0;
        #1;
        chk("sh_done_stall", 32'(mem_stall), 32'd0);
        step();
        drive(0, 0, 3'd0, 32'd0, 32'd0);
        step();

        drive(1, 0, F3_HU, 32'h0000_3001, 32'd0);
        #1;
        chk("lhu_misalign", 32'(misalign_err), 32'd1);
        chk("lhu_req", 32'(dm.dm_req), 32'd0);
        chk("lhu_stall", 32'(mem_stall), 32'd0);
        step();
        drive(0, 0, 3'd0, 32'd0, 32'd0);
        step();

        drive(1, 0, F3_W, 32'h0000_0100, 32'd0);
        step(); step(); step();
        #1;
        chk("to_busy3_err", 32'(timeout_err), 32'd0);
        chk("to_busy3_stall", 32'(mem_stall), 32'd1);
        step(); #1;
        chk("to_err", 32'(timeout_err), 32'd1);
        step(); #1;
        chk("to_done_load", load_data, 32'd0);
        chk("to_done_stall", 32'(mem_stall), 32'd0);
        chk("to_done_err", 32'(timeout_err), 32'd0);
        step();
        drive(0, 0, 3'd0, 32'd0, 32'd0);
        #1;
        chk("to_idle_req", 32'(dm.dm_req), 32'd0);
        step();

        drive(1, 0, F3_W, 32'h0000_0200, 32'd0);
        step();
        #2 rst = 1'b1;
        #1;
        chk("rstb_req", 32'(dm.dm_req), 32'd0);
        chk("rstb_stall", 32'(mem_stall), 32'd0);
        drive(0, 0, 3'd0, 32'd0, 32'd0);
        #2 rst = 1'b0;
        step();
        xact(1, 0, F3_W, 32'h0000_0204, 32'd0, 1, 32'hCAFE_F00D);

        drive(1, 0, F3_W, 32'h0000_0040, 32'd0);
        dm.dm_ack = 1'b1; dm.dm_rdata = 32'h1111_2222;
        #1;
        chk("b2b_req0", 32'(dm.dm_req), 32'd1);
        step();
        dm.dm_ack = 1'b0;
        #1;
        chk("b2b_req1", 32'(dm.dm_req), 32'd0);
        chk("b2b_load", load_data, 32'h1111_2222);
        step();
        drive(0, 1, F3_W, 32'h0000_0044, 32'h5566_7788);
        dm.dm_ack = 1'b1;
        #1;
        chk("b2b_req2", 32'(dm.dm_req), 32'd1);
        chk("b2b_wdata", dm.dm_wdata, 32'h5566_7788);
        step();
        dm.dm_ack = 1'b0;
        #1;
        chk("b2b_req3", 32'(dm.dm_req), 32'd0);
        step();
        drive(0, 0, 3'd0, 32'd0, 32'd0);
        step();

        xact(0, 1, F3_B,  32'h0000_5001, 32'h0000_00A5, 1, 32'd0);
        xact(1, 0, F3_H,  32'h0000_6002, 32'd0, 0, 32'h8001_7FFF);
        xact(1, 0, F3_HU, 32'h0000_6002, 32'd0, 2, 32'h8001_7FFF);
        xact(1, 0, F3_BU, 32'h0000_7001, 32'd0, 0, 32'h0000_F000);
        xact(1, 0, F3_B,  32'h0000_7002, 32'd0, 1, 32'h0055_0000);
        xact(0, 1, F3_W,  32'h0000_8002, 32'hFFFF_0000, -1, 32'd0);
        xact(1, 0, 3'b011, 32'h0000_8000, 32'd0, -1, 32'd0);
        xact(0, 1, F3_BU, 32'h0000_8000, 32'd0, -1, 32'd0);
        xact(0, 1, F3_H,  32'h0000_9000, 32'hBEEF_0123, 3, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
